// File: rtl/press_conditioner_if.sv
// Key/press bus for press_conditioner: raw active-low keys and freeze in,
// press pulses and debounced levels out.
interface press_conditioner_if;
  logic key_l_n;
  logic key_r_n;
  logic freeze;
  logic L;
  logic R;
  logic held_l;
  logic held_r;

  modport master (
    output key_l_n, key_r_n, freeze,
    input  L, R, held_l, held_r
  );

  modport slave (
    input  key_l_n, key_r_n, freeze,
    output L, R, held_l, held_r
  );
endinterface

// File: rtl/press_conditioner.sv
// Tug-of-war key front end: per-channel 2-FF sync, optional debounce FSM
// (enabled by DEBOUNCE_EN), and freeze-gated one-cycle press pulses.
module press_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  press_conditioner_if.slave bus
);

  localparam int unsigned NCH = 2;

  // Elaboration-time legality check on the debounce length.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("press_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NCH-1:0] key_n;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] s;
  logic [NCH-1:0] press_q;
  logic [NCH-1:0] held_q;

  assign key_n      = {bus.key_r_n, bus.key_l_n};
  assign bus.L      = press_q[0];
  assign bus.R      = press_q[1];
  assign bus.held_l = held_q[0];
  assign bus.held_r = held_q[1];

  // Two-flop synchronizer; keys inverted so s=1 means pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= ~key_n;
      s     <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                  SINGLE   = (DEBOUNCE_CYCLES == 1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_c;
    logic             held_c;
    logic             press_r;
    logic             held_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        RELEASED: begin
          if (s[i]) begin
            if (SINGLE) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
            end else begin
              state_nx = PRESS_PEND;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        PRESS_PEND: begin
          if (!s[i]) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            if (SINGLE) begin
              state_nx = RELEASED;
              cnt_nx   = '0;
            end else begin
              state_nx = RELEASE_PEND;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        RELEASE_PEND: begin
          if (s[i]) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end
      endcase
    end

    // Only a fresh press (not a release-bounce recovery) produces a pulse.
    always_comb begin
      press_c = 1'b0;
      held_c  = 1'b0;
      if ((state_nx == PRESSED) && ((state == RELEASED) || (state == PRESS_PEND)))
        press_c = 1'b1;
      if ((state_nx == PRESSED) || (state_nx == RELEASE_PEND))
        held_c = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        press_r <= 1'b0;
        held_r  <= 1'b0;
      end else begin
        press_r <= press_c & ~bus.freeze;
        held_r  <= held_c;
      end
    end

    assign press_q[i] = press_r;
    assign held_q[i]  = held_r;
  end
`else
  logic [NCH-1:0] s_prev;
  logic [NCH-1:0] press_r;

  // Undebounced: rising edge of the synced level, gated by freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev  <= '0;
      press_r <= '0;
    end else begin
      s_prev  <= s;
      press_r <= s & ~s_prev & {NCH{~bus.freeze}};
    end
  end

  assign press_q = press_r;
  assign held_q  = s;
`endif

endmodule

// File: tb/tb_press_conditioner.sv
// Directed bench for press_conditioner (N=4); expectations follow the
// debounced or undebounced build depending on DEBOUNCE_EN.
module tb_press_conditioner;

`ifdef DEBOUNCE_EN
  localparam int LAT       = 6;  // pulse appears after edge N+2
  localparam int HELD_EDGE = 6;  // held changes at the same edge
  localparam bit DEB       = 1'b1;
`else
  localparam int LAT       = 3;
  localparam int HELD_EDGE = 2;
  localparam bit DEB       = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  press_conditioner_if bus ();

  press_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset       = 1'b1;
    bus.key_l_n = 1'b1;
    bus.key_r_n = 1'b1;
    bus.freeze  = 1'b0;
    idle(3);
    check("rst_L", bus.L, 1'b0);
    check("rst_R", bus.R, 1'b0);
    check("rst_held_l", bus.held_l, 1'b0);
    check("rst_held_r", bus.held_r, 1'b0);
    reset = 1'b0;
    idle(2);

    // 1: steady left press held 20 cycles, then released
    bus.key_l_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t1_L", bus.L, 1'(k == LAT));
      check("t1_held_l", bus.held_l, 1'(k >= HELD_EDGE));
      check("t1_R", bus.R, 1'b0);
    end
    bus.key_l_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t1_rel_L", bus.L, 1'b0);
      check("t1_rel_held_l", bus.held_l, 1'(k < HELD_EDGE));
    end
    idle(4);

    // 2: right key low for only 3 cycles
    bus.key_r_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) bus.key_r_n = 1'b1;
      check("t2_R", bus.R, DEB ? 1'b0 : 1'(k == 3));
      check("t2_held_r", bus.held_r, DEB ? 1'b0 : 1'(k >= 2 && k <= 4));
      check("t2_L", bus.L, 1'b0);
    end
    idle(4);

    // 3: both keys pressed at the same edge
    bus.key_l_n = 1'b0;
    bus.key_r_n = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      check("t3_L", bus.L, 1'(k == LAT));
      check("t3_R", bus.R, 1'(k == LAT));
    end
    bus.key_l_n = 1'b1;
    bus.key_r_n = 1'b1;
    idle(12);

    // 4: press and release entirely under freeze
    bus.freeze  = 1'b1;
    bus.key_l_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t4_L", bus.L, 1'b0);
      check("t4_held_l", bus.held_l, 1'(k >= HELD_EDGE));
    end
    bus.key_l_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t4_rel_L", bus.L, 1'b0);
      check("t4_rel_held_l", bus.held_l, 1'(k < HELD_EDGE));
    end
    bus.freeze = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t4_nodefer_L", bus.L, 1'b0);
    end

    // 5: key held across a one-cycle reset
    bus.key_l_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t5_pre_L", bus.L, 1'(k == LAT));
    end
    reset = 1'b1;
    tick();
    check("t5_rst_L", bus.L, 1'b0);
    check("t5_rst_R", bus.R, 1'b0);
    check("t5_rst_held_l", bus.held_l, 1'b0);
    check("t5_rst_held_r", bus.held_r, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t5_L", bus.L, 1'(k == LAT));
      check("t5_held_l", bus.held_l, 1'(k >= HELD_EDGE));
      check("t5_R", bus.R, 1'b0);
    end
    bus.key_l_n = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
